// File: rtl/otter_mtimer.sv
`default_nettype none
// ============================================================================
//  Module   : otter_mtimer
//  Purpose  : Memory-mapped machine timer on the OTTER IOBUS. Provides a
//             64-bit MTIME counter with a programmable prescaler, a 64-bit
//             MTIMECMP compare register and a registered, level-sensitive
//             interrupt output.
//  Ports    : CLK        - system clock, all state updates on rising edge
//             RST        - synchronous active-high reset
//             IOBUS_ADDR - byte address from the MCU MEM stage
//             IOBUS_OUT  - write data from the MCU
//             IOBUS_WR   - single-cycle write strobe
//             rd_data    - combinational read data (0 when not selected)
//             sel        - address falls within this block's 32-byte window
//             timer_int  - registered interrupt level
//  Register map (byte offset):
//             0x00 MTIME_LO    0x04 MTIME_HI
//             0x08 MTIMECMP_LO 0x0C MTIMECMP_HI
//             0x10 CTRL {PRESCALE[8 +: PRESCALE_W], INT_EN[1], CNT_EN[0]}
//             0x14..0x1C reserved (read 0, writes ignored)
//  Revision : 1.0 - initial release
// ============================================================================
module otter_mtimer #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          PRESCALE_W = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] rd_data,
    output logic        sel,
    output logic        timer_int
);

    localparam logic [2:0] c_OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] c_OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] c_OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] c_OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] c_OFF_CTRL     = 3'd4;

    localparam logic [PRESCALE_W-1:0] c_PCNT_ONE = 1;

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic                  r_cnt_en;
    logic                  r_int_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  r_timer_int;

    logic [2:0]            w_offset;
    logic                  w_wr;
    logic                  w_tick;
    logic [31:0]           w_ctrl;
    logic [1:0]            w_unused_addr;

    // Byte lanes are not supported; the low address bits carry no meaning.
    assign w_unused_addr = IOBUS_ADDR[1:0];

    assign sel      = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign w_offset = IOBUS_ADDR[4:2];
    assign w_wr     = sel & IOBUS_WR;

    // One MTIME increment is due when the prescale counter has reached the
    // programmed terminal value. PRESCALE=0 therefore ticks every cycle.
    assign w_tick   = r_cnt_en & (r_pcnt == r_prescale);

    always_comb begin
        w_ctrl                    = '0;
        w_ctrl[0]                 = r_cnt_en;
        w_ctrl[1]                 = r_int_en;
        w_ctrl[8 +: PRESCALE_W]   = r_prescale;
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (w_offset)
                c_OFF_MTIME_LO: rd_data = r_mtime[31:0];
                c_OFF_MTIME_HI: rd_data = r_mtime[63:32];
                c_OFF_CMP_LO:   rd_data = r_mtimecmp[31:0];
                c_OFF_CMP_HI:   rd_data = r_mtimecmp[63:32];
                c_OFF_CTRL:     rd_data = w_ctrl;
                default:        rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_cnt_en    <= 1'b0;
            r_int_en    <= 1'b0;
            r_prescale  <= '0;
            r_pcnt      <= '0;
            r_timer_int <= 1'b0;
        end else begin
            // A software write to either MTIME half wins over the increment
            // for the full 64-bit value; the other half is left untouched.
            if (w_wr && (w_offset == c_OFF_MTIME_LO)) begin
                r_mtime[31:0] <= IOBUS_OUT;
            end else if (w_wr && (w_offset == c_OFF_MTIME_HI)) begin
                r_mtime[63:32] <= IOBUS_OUT;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr && (w_offset == c_OFF_CMP_LO)) begin
                r_mtimecmp[31:0] <= IOBUS_OUT;
            end
            if (w_wr && (w_offset == c_OFF_CMP_HI)) begin
                r_mtimecmp[63:32] <= IOBUS_OUT;
            end

            // Reprogramming CTRL restarts the prescale phase so the new
            // divider takes effect from a known starting point.
            if (w_wr && (w_offset == c_OFF_CTRL)) begin
                r_cnt_en   <= IOBUS_OUT[0];
                r_int_en   <= IOBUS_OUT[1];
                r_prescale <= IOBUS_OUT[8 +: PRESCALE_W];
                r_pcnt     <= '0;
            end else if (r_cnt_en) begin
                r_pcnt <= w_tick ? '0 : (r_pcnt + c_PCNT_ONE);
            end

            // Compare uses pre-edge values, so the level follows the
            // condition with exactly one cycle of latency.
            r_timer_int <= r_int_en & (r_mtime >= r_mtimecmp);
        end
    end

    assign timer_int = r_timer_int;

endmodule
`default_nettype wire
